rf_wb_arbiter: RTL and testbench

//  Schedules the single register-file write port between two writeback sources: ALU result and load data.

---
 rtl/rf_wb_arbiter_pkg.sv | 20 ++
 rtl/rf_wb_arbiter_fifo.sv | 55 +++++
 rtl/rf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  typedef struct packed {
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Small skid FIFO holding pending writeback requests for one source.
module rf_wb_arbiter_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  wb_req_t                    data_i,
  input  logic                       pop_i,
  output logic                       empty_c,
  output wb_req_t                    head_c,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok  = push_i && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop_i && !empty_c;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin scheduler of ALU/load writebacks onto the single register-file
// write port, plus a busy scoreboard of destinations with writes in flight.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned RF_ADDR_W  = 6,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_wa,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_wa,
  input  logic [DATA_W-1:0]    alu_wd,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_wa,
  input  logic [DATA_W-1:0]    ld_wd,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]    rf_wd,
  output logic [NUM_REGS-1:0]  busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             alu_pop, ld_pop, alu_empty, ld_empty;
  logic [CNT_W-1:0] alu_count, ld_count;
  wb_req_t          alu_head, ld_head, win_head;

  grant_t               last_grant_q, last_grant_d;
  logic                 rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]    rf_wd_q, rf_wd_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  // Ready depends on occupancy only, so a full FIFO never sees push+pop together.
  assign alu_ready = rst_n && (alu_count < CNT_W'(FIFO_DEPTH));
  assign ld_ready  = rst_n && (ld_count < CNT_W'(FIFO_DEPTH));

  rf_wb_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (alu_valid && alu_ready),
    .data_i  ('{wa: alu_wa, wd: alu_wd}),
    .pop_i   (alu_pop),
    .empty_c (alu_empty),
    .head_c  (alu_head),
    .count_o (alu_count)
  );

  rf_wb_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ld_valid && ld_ready),
    .data_i  ('{wa: ld_wa, wd: ld_wd}),
    .pop_i   (ld_pop),
    .empty_c (ld_empty),
    .head_c  (ld_head),
    .count_o (ld_count)
  );

  always_comb begin
    alu_pop      = 1'b0;
    ld_pop       = 1'b0;
    win_head     = alu_head;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    busy_d       = busy_q;

    if (!alu_empty && (ld_empty || last_grant_q == GNT_LD)) begin
      alu_pop      = 1'b1;
      last_grant_d = GNT_ALU;
    end else if (!ld_empty) begin
      ld_pop       = 1'b1;
      win_head     = ld_head;
      last_grant_d = GNT_LD;
    end

    // A zero-register entry still consumes its slot but never enables the write.
    if (alu_pop || ld_pop) begin
      rf_we_d = (win_head.wa != ZERO_REG);
      rf_wa_d = RF_ADDR_W'(win_head.wa);
      rf_wd_d = win_head.wd;
    end

    // Set after clear so a same-edge reissue keeps the register busy.
    if (rf_we_d) busy_d[win_head.wa] = 1'b0;
    if (issue_valid && issue_wa != ZERO_REG) busy_d[issue_wa] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GNT_LD;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_wa;
  logic [31:0] ld_wd;
  logic        rf_we;
  logic [5:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.RF_ADDR_W(6), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wa(issue_wa),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed { logic [4:0] wa; logic [31:0] wd; } mreq_t;

  // Reference model: two bounded queues, last-winner flag, committed outputs.
  mreq_t       aq[$], lq[$];
  bit          m_alu_won_last;
  logic        m_we;
  logic [5:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_busy;

  bit          dut_alu_rdy, dut_ld_rdy;
  int          dlog_wa[$], dlog_cyc[$];

  typedef struct {
    logic rst; logic av; logic [4:0] awa; logic [31:0] awd;
    logic iv; logic [4:0] iwa;
    logic e_rdy; logic e_we; logic [5:0] e_wa; logic [31:0] e_wd; logic [31:0] e_busy;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    aq.delete(); lq.delete();
    m_alu_won_last = 1'b0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
  endtask

  task automatic model_edge();
    mreq_t w;
    bit got, a_acc, l_acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a_acc = alu_valid && aq.size() < 2;
    l_acc = ld_valid && lq.size() < 2;
    got = 1'b0;
    if (aq.size() > 0 && (lq.size() == 0 || !m_alu_won_last)) begin
      w = aq.pop_front(); m_alu_won_last = 1'b1; got = 1'b1;
    end else if (lq.size() > 0) begin
      w = lq.pop_front(); m_alu_won_last = 1'b0; got = 1'b1;
    end
    m_we = 1'b0;
    if (got) begin
      m_we = (w.wa != 5'd31);
      m_wa = {1'b0, w.wa};
      m_wd = w.wd;
      if (m_we) m_busy[w.wa] = 1'b0;
    end
    if (issue_valid && issue_wa != 5'd31) m_busy[issue_wa] = 1'b1;
    if (a_acc) aq.push_back({alu_wa, alu_wd});
    if (l_acc) lq.push_back({ld_wa, ld_wd});
  endtask

  // One clock: inputs are already applied; compare against the model, then advance.
  task automatic step();
    #1;
    dut_alu_rdy = alu_ready;
    dut_ld_rdy  = ld_ready;
    check("alu_ready", alu_ready, rst_n && aq.size() < 2);
    check("ld_ready", ld_ready, rst_n && lq.size() < 2);
    check("rf_we", rf_we, m_we);
    check("rf_wa", rf_wa, m_wa);
    check("rf_wd", rf_wd, m_wd);
    check("busy", busy, m_busy);
    if (rf_we === 1'b1) begin
      dlog_wa.push_back(int'(rf_wa));
      dlog_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    ld_valid = 1'b0; ld_wa = '0; ld_wd = '0;
    issue_valid = 1'b0; issue_wa = '0;
  endtask

  initial begin
    mreq_t pa[$], pl[$];
    int a_stall, l_stall, n;
    int exp3[8];
    bit a_pend, l_pend;

    tbl[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 32'd0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b0, 6'd0, 32'd0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b0, 6'd0, 32'd0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 1'b0, 6'd0, 32'd0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 1'b0, 6'd0, 32'd0, 32'h20};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 32'h80};
    tbl[6] = '{1'b1, 1'b1, 5'd7, 32'h1234,     1'b1, 5'd31, 1'b1, 1'b0, 6'd5, 32'hDEADBEEF, 32'h80};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 1'b0, 6'd5, 32'hDEADBEEF, 32'h80};
    tbl[8] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 6'd7, 32'h1234, 32'h80};
    tbl[9] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b0, 6'd7, 32'h1234, 32'h80};

    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset, single write latency, scoreboard set/clear/same-edge and R31 issue.
    for (int i = 0; i < 10; i++) begin
      rst_n = tbl[i].rst;
      alu_valid = tbl[i].av; alu_wa = tbl[i].awa; alu_wd = tbl[i].awd;
      issue_valid = tbl[i].iv; issue_wa = tbl[i].iwa;
      #1;
      check($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_ld_ready", i), ld_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_rf_we", i), rf_we, tbl[i].e_we);
      check($sformatf("vec%0d_rf_wa", i), rf_wa, tbl[i].e_wa);
      check($sformatf("vec%0d_rf_wd", i), rf_wd, tbl[i].e_wd);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      step();
    end

    // Contention with backpressure: strict alternation starting with ALU.
    idle_inputs(); rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pa.push_back({5'(1 + i), 32'hA000_0000 + 32'(i)});
      pl.push_back({5'(8 + i), 32'hB000_0000 + 32'(i)});
    end
    exp3 = '{1, 8, 2, 9, 3, 10, 4, 11};
    dlog_wa.delete(); dlog_cyc.delete();
    a_stall = 0; l_stall = 0;
    for (int k = 0; k < 40 && dlog_wa.size() < 8; k++) begin
      alu_valid = (pa.size() > 0);
      if (alu_valid) begin alu_wa = pa[0].wa; alu_wd = pa[0].wd; end
      ld_valid = (pl.size() > 0);
      if (ld_valid) begin ld_wa = pl[0].wa; ld_wd = pl[0].wd; end
      step();
      if (alu_valid && !dut_alu_rdy) a_stall++;
      if (ld_valid && !dut_ld_rdy) l_stall++;
      if (alu_valid && dut_alu_rdy) void'(pa.pop_front());
      if (ld_valid && dut_ld_rdy) void'(pl.pop_front());
    end
    check("contention_commit_count", dlog_wa.size(), 8);
    n = (dlog_wa.size() < 8) ? dlog_wa.size() : 8;
    for (int i = 0; i < n; i++) check($sformatf("contention_order%0d", i), dlog_wa[i], exp3[i]);
    if (n == 8) check("contention_span", dlog_cyc[7] - dlog_cyc[0], 7);
    check("alu_backpressure_cycles", a_stall, 1);
    check("ld_backpressure_cycles", l_stall, 2);

    // Zero register consumes a slot; the queued ALU write follows next cycle.
    idle_inputs(); rst_n = 1'b0; step(); rst_n = 1'b1;
    ld_valid = 1'b1; ld_wa = 5'd31; ld_wd = 32'h55;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'h33;
    step();
    idle_inputs();
    check("zero_reg_we", rf_we, 1'b0);
    step();
    check("after_zero_we", rf_we, 1'b1);
    check("after_zero_wa", rf_wa, 6'd3);
    check("after_zero_wd", rf_wd, 32'h33);
    step();

    // Randomized traffic with occasional mid-stream reset.
    a_pend = 1'b0; l_pend = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if (!a_pend && $urandom_range(0, 99) < 60) begin
        a_pend = 1'b1; alu_wa = 5'($urandom_range(0, 31)); alu_wd = $urandom;
      end
      if (!l_pend && $urandom_range(0, 99) < 55) begin
        l_pend = 1'b1; ld_wa = 5'($urandom_range(0, 31)); ld_wd = $urandom;
      end
      alu_valid = a_pend;
      ld_valid  = l_pend;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_wa = 5'($urandom_range(0, 31));
      step();
      if (a_pend && dut_alu_rdy) a_pend = 1'b0;
      if (l_pend && dut_ld_rdy) l_pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
